// File: rtl/uart_tx_frame_pkg.sv
// Shared types and constants for the UART transmitter.
// UART_TX_STOP2_EN adds the STOP2 state for two-stop-bit frames.
package uart_tx_pkg;

  localparam int PRESCALE_W = 6;
  localparam int BITCNT_W   = 4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_TX_STOP2_EN
    , STOP2
`endif
  } tx_state_t;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Parallel-load and serial-output signals of the UART transmitter.
// The master side loads words; the slave side is the transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  import uart_tx_pkg::*;

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    output TX_OUT, busy
  );

endinterface

// File: rtl/uart_tx_frame_bit_timer.sv
// Bit-period timer: counts oversampling clocks within a bit and counts
// the data bits sent so far in the current frame.
module uart_tx_bit_timer
  import uart_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  active,
  input  logic                  in_data,
  input  logic                  bit_clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_done,
  output logic [BITCNT_W-1:0]   bit_cnt
);

  logic [PRESCALE_W-1:0] edge_cnt;

  assign bit_done = active && (edge_cnt == prescale - 1'b1);

  // The edge counter idles at zero so every frame starts on a fresh bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (!active || bit_done)
        edge_cnt <= '0;
      else
        edge_cnt <= edge_cnt + 1'b1;

      if (bit_clr)
        bit_cnt <= '0;
      else if (bit_done && in_data)
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// UART_TX_STOP2_EN appends a second stop bit to every frame.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  bus
);

  localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_en_q;
  logic [PRESCALE_W-1:0] p_q;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  load;
  logic                  bit_done;
  logic [BITCNT_W-1:0]   bit_cnt;

  uart_tx_bit_timer u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .active   (state_q != IDLE),
    .in_data  (state_q == DATA),
    .bit_clr  (load),
    .prescale (p_q),
    .bit_done (bit_done),
    .bit_cnt  (bit_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      p_q      <= PRESCALE_W'(1);
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      if (load) begin
        par_q    <= ^bus.P_DATA ^ (bus.PAR_TYP == PAR_ODD);
        par_en_q <= bus.PAR_EN;
        p_q      <= (bus.Prescale == '0) ? PRESCALE_W'(1) : bus.Prescale;
      end
    end
  end

  // Line level is derived from the next state so TX_OUT and busy leave flops.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    load    = 1'b0;
    tx_d    = 1'b1;
    busy_d  = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.Data_Valid) begin
          load    = 1'b1;
          shift_d = bus.P_DATA;
          state_d = START;
        end
      end
      START: begin
        if (bit_done)
          state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt == LAST_BIT)
            state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_done)
          state_d = STOP;
      end
      STOP: begin
        if (bit_done)
`ifdef UART_TX_STOP2_EN
          state_d = STOP2;
`else
          state_d = IDLE;
`endif
      end
`ifdef UART_TX_STOP2_EN
      STOP2: begin
        if (bit_done)
          state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    case (state_d)
      IDLE:    begin tx_d = 1'b1; busy_d = 1'b0; end
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.TX_OUT = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomized bench for uart_tx_frame: each frame is predicted as a list of
// line levels and compared cycle by cycle against TX_OUT and busy.
module tb_uart_tx_frame;

`ifdef UART_TX_STOP2_EN
  localparam int N_STOP = 2;
`else
  localparam int N_STOP = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   check_count = 0;
  int   error_count = 0;

  uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: plain frame; 1: hostile input changes during DATA; 2: hold valid with next_data
  task automatic applyStimulus(input logic [7:0] data, input logic pe, input logic pt,
                               input logic [5:0] ps, input int mode, input logic [7:0] next_data);
    logic bits[$];
    int   p;
    int   total;
    bus.P_DATA     = data;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Prescale   = ps;
    bus.Data_Valid = 1'b1;
    tick();

    p = (ps == 0) ? 1 : int'(ps);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (pe) bits.push_back(((data ^ 8'h00) == 8'h00) ? pt : ((^data) ^ pt));
    for (int i = 0; i < N_STOP; i++) bits.push_back(1'b1);
    total = bits.size() * p;

    if (mode == 2) bus.P_DATA = next_data;
    else bus.Data_Valid = 1'b0;

    for (int k = 0; k < total; k++) begin
      checkOutput("tx_bit", 32'(bus.TX_OUT), 32'(bits[k / p]));
      checkOutput("busy_frame", 32'(bus.busy), 32'd1);
      if (mode == 1 && k == 3 * p + 1) begin
        bus.Data_Valid = 1'b1;
        bus.P_DATA     = 8'hFF;
        bus.Prescale   = ps + 6'd5;
        bus.PAR_EN     = ~pe;
        bus.PAR_TYP    = ~pt;
      end else if (mode == 1 && k == 3 * p + 2) begin
        bus.Data_Valid = 1'b0;
      end
      tick();
    end
    checkOutput("idle_tx", 32'(bus.TX_OUT), 32'd1);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.P_DATA     = '0;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Prescale   = 6'd1;
    rst = 1'b1;
    repeat (3) tick();
    checkOutput("reset_tx", 32'(bus.TX_OUT), 32'd1);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("idle20_tx", 32'(bus.TX_OUT), 32'd1);
      checkOutput("idle20_busy", 32'(bus.busy), 32'd0);
    end

    applyStimulus(8'hA5, 1'b1, 1'b0, 6'd8, 0, 8'h00);
    applyStimulus(8'h01, 1'b1, 1'b1, 6'd16, 0, 8'h00);
    applyStimulus(8'h01, 1'b0, 1'b1, 6'd16, 0, 8'h00);
    applyStimulus(8'h96, 1'b1, 1'b0, 6'd4, 1, 8'h00);
    applyStimulus(8'h5E, 1'b0, 1'b1, 6'd1, 1, 8'h00);
    applyStimulus(8'h3C, 1'b0, 1'b0, 6'd2, 2, 8'hC3);
    applyStimulus(8'hC3, 1'b0, 1'b0, 6'd2, 0, 8'h00);

    // Reset during data bit 2 with one cycle per bit
    bus.P_DATA     = 8'h9A;
    bus.PAR_EN     = 1'b0;
    bus.Prescale   = 6'd1;
    bus.Data_Valid = 1'b1;
    tick();
    bus.Data_Valid = 1'b0;
    repeat (3) tick();
    checkOutput("pre_reset_bit2", 32'(bus.TX_OUT), 32'd0);
    checkOutput("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midreset_tx", 32'(bus.TX_OUT), 32'd1);
    checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
    tick();
    checkOutput("postreset_tx", 32'(bus.TX_OUT), 32'd1);
    checkOutput("postreset_busy", 32'(bus.busy), 32'd0);
    applyStimulus(8'h55, 1'b1, 1'b0, 6'd1, 0, 8'h00);

    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      logic [5:0] ps;
      d  = 8'($urandom);
      ps = 6'($urandom_range(0, 6));
      applyStimulus(d, 1'($urandom), 1'($urandom), ps, int'($urandom_range(0, 1)), 8'h00);
      repeat ($urandom_range(0, 3)) begin
        tick();
        checkOutput("gap_tx", 32'(bus.TX_OUT), 32'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Oversampled-clock UART transmitter: the TX side of the UART block, sharing the RX path's `Prescale` oversampling clock so both directions use one clock and one baud setting. It accepts a parallel word with a single-cycle valid strobe and serializes it LSB-first on `TX_OUT` as a frame: start bit, data, optional parity, stop. Each bit is held for `Prescale` clock cycles. It sits between the register-file/FIFO side and the serial pin.

## Interface
- `DATA_WIDTH`, default 8, serialized word width.
- `clk`  input  1  oversampling clock, same clock as the RX bit timer.
- `rst`  input  1  synchronous, active-high reset.
- `P_DATA`  input  DATA_WIDTH  parallel word to transmit.
- `Data_Valid`  input  1  load strobe; accepted only when `busy`=0.
- `PAR_EN`  input  1  1 = append a parity bit.
- `PAR_TYP`  input  1  0 = even parity, 1 = odd parity.
- `Prescale`  input  6  clock cycles per bit, legal values 1..63; 0 behaves as 1.
- `TX_OUT`  output  1  serial line, idle high.
- `busy`  output  1  high while a frame is in flight.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP (and STOP2 under the macro).
- IDLE: `TX_OUT`=1 and `busy`=0. If `Data_Valid`=1, these are latched on that edge: `P_DATA`, `PAR_EN`, `PAR_TYP`, `Prescale`, and parity = ^P_DATA ^ PAR_TYP. The FSM then goes to START.
- START: `TX_OUT`=0 for one bit period, then DATA.
- DATA: `TX_OUT` = the shift register's LSB. The register shifts right at the end of each bit period. After DATA_WIDTH bits, the FSM goes to PARITY if the latched PAR_EN=1, otherwise to STOP.
- PARITY: `TX_OUT` = the latched parity bit for one bit period, then STOP.
- STOP: `TX_OUT`=1 for one bit period, then IDLE.
- Inputs are sampled only at acceptance. Changes to `P_DATA`, `PAR_*` or `Prescale` mid-frame have no effect.
- `Data_Valid` while `busy`=1 is ignored and dropped. There is no buffering, so the upstream FIFO holds the word until `busy`=0.
- Bit timer:
  - The edge counter counts 0..P-1, where P is the latched Prescale, with 0 mapped to 1.
  - `bit_done` asserts when the count equals P-1. The counter wraps to 0 on that edge.
  - The bit counter increments on `bit_done` in DATA and clears on entry to START.
  - The counters are 6-bit and 4-bit respectively and never overflow for legal parameters.

## Timing
- Reset (any cycle, including mid-frame): on the next edge `TX_OUT`=1, `busy`=0, state=IDLE, and all counters are 0. The partial frame is abandoned.
- Latency: the start bit appears on `TX_OUT` on the edge after `Data_Valid` is accepted. `busy` rises on that same edge.
- Outputs are registered: `TX_OUT` and `busy` come from flops with no combinational path from the inputs.
- Frame length is (1 + DATA_WIDTH + PAR_EN + N_STOP) × P cycles, where N_STOP = 1, or 2 under the macro. `busy` is high for exactly that many cycles.
- Frame-to-frame: `busy` falls on the edge after the last stop cycle. At least one IDLE cycle (`TX_OUT`=1) separates back-to-back frames.
- With P=1, every bit lasts one cycle and the FSM advances every cycle.

## Configuration
- `UART_TX_STOP2_EN` defined: a STOP2 state follows STOP. Every frame then carries two stop bits, each P cycles, and frame length includes N_STOP=2.
- `UART_TX_STOP2_EN` undefined: the STOP2 state and its logic are absent, and the frame has one stop bit.

## Structure
- Package `uart_tx_pkg` holds:
  - the state enum `tx_state_t`;
  - the constants `PAR_EVEN`=0 and `PAR_ODD`=1;
  - `PRESCALE_W`=6 and `BITCNT_W`=4.
- Sub-module `uart_tx_bit_timer` contains the edge counter and bit counter and produces `bit_done` and `bit_cnt`. It is instantiated once. The top level holds the FSM, shift register and parity.

## Test plan
- Reset and idle: reset, then 20 idle cycles → `TX_OUT`=1 and `busy`=0 throughout.
- Even-parity frame: P=8, P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0 → `TX_OUT` = 0,1,0,1,0,0,1,0,1,0,1, each bit held 8 cycles. `busy` is high 88 cycles.
- Odd parity, no parity: P=16, P_DATA=8'h01, PAR_TYP=1 → parity bit 0. Repeating with PAR_EN=0 gives 160 cycles, with no parity bit.
- Mid-frame robustness:
  - `Data_Valid` pulses with 8'hFF during the DATA state → ignored, and the original frame is unaltered.
  - Changing `Prescale` mid-frame → does not change the bit width.
- Back-to-back: `Data_Valid` held high with 8'h3C then 8'hC3 → two complete frames separated by exactly one idle cycle.
- Reset mid-frame: assert `rst` in the 3rd data bit with P=1 → next edge gives `TX_OUT`=1 and `busy`=0. A following 8'h55 frame transmits correctly.
